// File: rtl/eight_queen_run_controller_if.sv
// Row read-back stream from the run controller to the host.
//   valid : row data valid (controller drives)
//   ready : host accepts the row (host drives)
//   data  : captured row, one-hot column
//   row   : row index of data
//   last  : high with row 7
interface eight_queen_run_controller_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic [2:0] row;
  logic       last;

  modport master (output valid, data, row, last, input ready);
  modport slave  (input valid, data, row, last, output ready);
endinterface

// File: rtl/eight_queen_run_controller.sv
// Run controller for the stacked eight-queen solver.
// Resets the solver, starts it, waits for done/no_answer under a watchdog,
// captures the 8 solution rows, checks the placement is legal, streams the
// rows to the host and finishes with a one-cycle status pulse.
// Ports:
//   clk, user_reset_n          : clock, asynchronous active-low reset
//   host_req / host_busy       : run request (ignored unless idle) / busy flag
//   sol_reset, sol_start       : solver reset and level start
//   sol_ready, sol_done,
//   sol_no_answer, sol_bus     : solver status and one-hot row bus
//   rd                         : row read-back stream (valid/ready)
//   status, status_valid       : 0=OK 1=NO_ANSWER 2=TIMEOUT 3=INVALID, end pulse
module eight_queen_run_controller #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMEOUT_W      = 20,
  parameter int RESET_CYCLES   = 4
) (
  input  logic                                clk,
  input  logic                                user_reset_n,
  input  logic                                host_req,
  output logic                                host_busy,
  output logic                                sol_reset,
  output logic                                sol_start,
  input  logic                                sol_ready,
  input  logic                                sol_done,
  input  logic                                sol_no_answer,
  input  logic [7:0]                          sol_bus,
  eight_queen_run_controller_if.master        rd,
  output logic [1:0]                          status,
  output logic                                status_valid
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]      RST_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_ONE   = TIMEOUT_W'(1);

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_NO_ANSWER = 2'd1;
  localparam logic [1:0] ST_TIMEOUT   = 2'd2;
  localparam logic [1:0] ST_INVALID   = 2'd3;

  typedef enum logic [2:0] {
    IDLE, RST_SOLVER, WAIT_READY, START, CAPTURE, CHECK, STREAM, REPORT
  } state_t;

  state_t              state, next_state;
  logic [RC_W-1:0]     rst_cnt;
  logic [TIMEOUT_W-1:0] wd;
  logic [2:0]          idx;        // capture index, then stream index
  logic [7:0][7:0]     row_buf;
  logic [7:0]          col_mask;
  logic                invalid;
  logic [1:0]          status_q, status_d;

  logic row_onehot, row_collide, capture_en, diag_hit;

  // Column index of a one-hot row; meaningless for non-one-hot rows, which
  // are already flagged invalid during capture.
  function automatic logic [2:0] col_of(input logic [7:0] b);
    col_of = 3'd0;
    for (int k = 0; k < 8; k++)
      if (b[k]) col_of = 3'(k);
  endfunction

  // Two queens share a diagonal when their column distance equals their row distance.
  function automatic logic diag_conflict(input logic [7:0][7:0] rows);
    logic signed [3:0] d;
    logic [3:0]        ad;
    diag_conflict = 1'b0;
    for (int i = 0; i < 7; i++)
      for (int j = i + 1; j < 8; j++) begin
        d  = $signed({1'b0, col_of(rows[i])}) - $signed({1'b0, col_of(rows[j])});
        ad = d[3] ? 4'(-d) : 4'(d);
        if (ad == 4'(j - i)) diag_conflict = 1'b1;
      end
  endfunction

  assign row_onehot  = (sol_bus != 8'd0) && ((sol_bus & (sol_bus - 8'd1)) == 8'd0);
  assign row_collide = |(col_mask & sol_bus);
  // Row 0 is taken in the same cycle done is seen, rows 1..7 in CAPTURE.
  assign capture_en  = ((state == START) && sol_done) || (state == CAPTURE);
  assign diag_hit    = diag_conflict(row_buf);

  // State register
  always_ff @(posedge clk or negedge user_reset_n) begin
    if (!user_reset_n) state <= IDLE;
    else               state <= next_state;
  end

  // Next-state and run result
  always_comb begin
    next_state = state;
    status_d   = status_q;
    case (state)
      IDLE: if (host_req) begin
        next_state = RST_SOLVER;
        status_d   = ST_OK;
      end
      RST_SOLVER: if (rst_cnt == RST_LAST) next_state = WAIT_READY;
      WAIT_READY: begin
        if (sol_ready) next_state = START;
        else if (wd == WD_LAST) begin
          next_state = REPORT;
          status_d   = ST_TIMEOUT;
        end
      end
      START: begin
        if (sol_done) next_state = CAPTURE;
        else if (sol_no_answer) begin
          next_state = REPORT;
          status_d   = ST_NO_ANSWER;
        end else if (wd == WD_LAST) begin
          next_state = REPORT;
          status_d   = ST_TIMEOUT;
        end
      end
      CAPTURE: if (idx == 3'd7) next_state = CHECK;
      CHECK: begin
        if (invalid || diag_hit) begin
          next_state = REPORT;
          status_d   = ST_INVALID;
        end else begin
          next_state = STREAM;
        end
      end
      STREAM: if (rd.ready && (idx == 3'd7)) next_state = REPORT;
      REPORT: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    host_busy    = (state != IDLE);
    sol_reset    = (state == RST_SOLVER);
    sol_start    = (state == START) || (state == CAPTURE);
    status_valid = (state == REPORT);
    rd.valid     = (state == STREAM);
    rd.data      = (state == STREAM) ? row_buf[idx] : 8'd0;
    rd.row       = (state == STREAM) ? idx : 3'd0;
    rd.last      = (state == STREAM) && (idx == 3'd7);
  end

  assign status = status_q;

  // Counters, capture buffer and check flags
  always_ff @(posedge clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      rst_cnt  <= '0;
      wd       <= '0;
      idx      <= 3'd0;
      row_buf  <= '0;
      col_mask <= 8'd0;
      invalid  <= 1'b0;
      status_q <= ST_OK;
    end else begin
      status_q <= status_d;
      case (state)
        IDLE: if (host_req) begin
          rst_cnt  <= '0;
          idx      <= 3'd0;
          row_buf  <= '0;
          col_mask <= 8'd0;
          invalid  <= 1'b0;
        end
        RST_SOLVER: begin
          rst_cnt <= rst_cnt + RC_W'(1);
          wd      <= '0;
        end
        // Leaving for START restarts the watchdog so START sees a full window.
        WAIT_READY: wd <= sol_ready ? '0 : (wd + WD_ONE);
        START:      wd <= wd + WD_ONE;
        STREAM:     if (rd.ready) idx <= idx + 3'd1;
        default: ;
      endcase
      // idx wraps 7 -> 0 after the last capture, ready for streaming.
      if (capture_en) begin
        row_buf[idx] <= sol_bus;
        idx          <= idx + 3'd1;
        col_mask     <= col_mask | sol_bus;
        if (!row_onehot || row_collide) invalid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eight_queen_run_controller.sv
module tb_eight_queen_run_controller;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int RESET_CYCLES   = 4;
  localparam logic [1:0] ST_OK = 2'd0, ST_NA = 2'd1, ST_TO = 2'd2, ST_INV = 2'd3;

  logic       clk = 1'b0;
  logic       user_reset_n = 1'b1;
  logic       host_req = 1'b0;
  logic       sol_ready = 1'b1;
  logic       sol_done = 1'b0;
  logic       sol_no_answer = 1'b0;
  logic [7:0] sol_bus = 8'd0;
  logic       host_busy, sol_reset, sol_start, status_valid;
  logic [1:0] status;

  eight_queen_run_controller_if rd_if();

  eight_queen_run_controller #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TIMEOUT_W(20), .RESET_CYCLES(RESET_CYCLES)
  ) dut (
    .clk(clk), .user_reset_n(user_reset_n), .host_req(host_req), .host_busy(host_busy),
    .sol_reset(sol_reset), .sol_start(sol_start), .sol_ready(sol_ready),
    .sol_done(sol_done), .sol_no_answer(sol_no_answer), .sol_bus(sol_bus),
    .rd(rd_if), .status(status), .status_valid(status_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_row;
    logic [7:0] data;
    logic [2:0] row;
    logic       last;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   bp_mode = 1'b0;

  logic [7:0] legal  [0:7];
  logic [7:0] dupcol [0:7];
  logic [7:0] diag   [0:7];
  logic [7:0] zrow   [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_rows(input logic [7:0] rows [0:7]);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.is_row = 1'b1; e.data = rows[k]; e.row = 3'(k); e.last = (k == 7); e.st = 2'd0;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_status(input logic [1:0] s);
    exp_t e;
    e.is_row = 1'b0; e.data = 8'd0; e.row = 3'd0; e.last = 1'b0; e.st = s;
    exp_q.push_back(e);
  endtask

  // Pulse host_req, count sol_reset cycles, return at the negedge of START cycle 0.
  task automatic begin_run();
    int  rst_len;
    bit  seen;
    @(posedge clk); #1 host_req = 1'b1;
    @(posedge clk); #1 host_req = 1'b0;
    rst_len = 0; seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (sol_reset) rst_len++;
      if (sol_start) seen = 1'b1;
    end
    chk("start_seen", seen, 1);
    chk("reset_len", rst_len, RESET_CYCLES);
  endtask

  // Drive n rows on consecutive cycles; sol_done only with row 0.
  task automatic drive_rows(input logic [7:0] rows [0:7], input int n, input bit with_na);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      sol_done      = (k == 0);
      sol_no_answer = (k == 0) && with_na;
      sol_bus       = rows[k];
      @(posedge clk); #1;
    end
    sol_done = 1'b0; sol_no_answer = 1'b0; sol_bus = 8'd0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!host_busy && exp_q.size() == 0) done = 1'b1;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_idle"}, host_busy, 0);
  endtask

  // Backpressure generator
  initial forever begin
    @(posedge clk); #1;
    if (bp_mode) rd_if.ready = ~rd_if.ready;
  end

  // Monitor: compare every presented row / status against the scoreboard head
  initial forever begin
    exp_t h;
    @(negedge clk);
    if (user_reset_n) begin
      if (sol_reset) chk("start_during_reset", sol_start, 0);
      if (rd_if.valid) begin
        if (exp_q.size() == 0 || !exp_q[0].is_row) begin
          checks++; errors++;
          $display("FAIL unexpected_row: got row %0d data %0h, required no transfer", rd_if.row, rd_if.data);
        end else begin
          chk("rd_data", rd_if.data, exp_q[0].data);
          chk("rd_row", rd_if.row, exp_q[0].row);
          chk("rd_last", rd_if.last, exp_q[0].last);
          if (rd_if.ready) h = exp_q.pop_front();
        end
      end
      if (status_valid) begin
        if (exp_q.size() == 0 || exp_q[0].is_row) begin
          checks++; errors++;
          $display("FAIL unexpected_status: got status %0d, required no status pulse", status);
        end else begin
          chk("status", status, exp_q[0].st);
          h = exp_q.pop_front();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required finish");
    $fatal(1);
  end

  initial begin
    int  n, cyc, xf;
    bit  got;
    legal  = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
    dupcol = '{8'h01, 8'h01, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
    diag   = '{8'h01, 8'h02, 8'h80, 8'h20, 8'h04, 8'h40, 8'h10, 8'h08};
    zrow   = '{8'h01, 8'h10, 8'h80, 8'h00, 8'h04, 8'h40, 8'h02, 8'h08};
    rd_if.ready = 1'b1;

    #2 user_reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", host_busy, 0);
    chk("rst_sol_reset", sol_reset, 0);
    chk("rst_sol_start", sol_start, 0);
    chk("rst_rd_valid", rd_if.valid, 0);
    chk("rst_rd_data", rd_if.data, 0);
    chk("rst_status", status, 0);
    chk("rst_status_valid", status_valid, 0);
    @(negedge clk) user_reset_n = 1'b1;

    // Legal solution, ready tied high: 8 transfers in 8 cycles
    push_rows(legal); push_status(ST_OK);
    begin_run();
    drive_rows(legal, 8, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = rd_if.valid;
    end
    chk("stream_seen", got, 1);
    cyc = 0; xf = 0;
    while (got && xf < 8 && cyc < 40) begin
      if (rd_if.valid && rd_if.ready) xf++;
      cyc++;
      if (xf < 8) @(negedge clk);
    end
    chk("stream_cycles", cyc, 8);
    wait_idle("legal");
    chk("status_hold_ok", status, ST_OK);

    // Backpressure, done together with no_answer, host_req while busy
    push_rows(legal); push_status(ST_OK);
    begin_run();
    bp_mode = 1'b1;
    drive_rows(legal, 8, 1'b1);
    host_req = 1'b1;
    @(posedge clk); #1 host_req = 1'b0;
    wait_idle("backpressure");
    bp_mode = 1'b0;
    rd_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_req_ignored", host_busy, 0);

    // No answer 30 cycles after start
    push_status(ST_NA);
    begin_run();
    repeat (30) @(posedge clk);
    #1 sol_no_answer = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("na_start_drop", sol_start, 0);
    sol_no_answer = 1'b0;
    wait_idle("no_answer");
    chk("status_hold_na", status, ST_NA);

    // Silent solver: timeout 50 cycles after START entry
    push_status(ST_TO);
    begin_run();
    n = 0; got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      n++;
      got = status_valid;
    end
    chk("timeout_latency", n, TIMEOUT_CYCLES);
    wait_idle("timeout");

    // Illegal placements are reported, never streamed
    push_status(ST_INV);
    begin_run();
    drive_rows(dupcol, 8, 1'b0);
    wait_idle("dup_column");
    push_status(ST_INV);
    begin_run();
    drive_rows(diag, 8, 1'b0);
    wait_idle("diagonal");
    push_status(ST_INV);
    begin_run();
    drive_rows(zrow, 8, 1'b0);
    wait_idle("zero_row");

    // Async reset during capture of row 4: immediate quiet outputs, no status
    begin_run();
    drive_rows(legal, 4, 1'b0);
    user_reset_n = 1'b0;
    #1;
    chk("abort_busy", host_busy, 0);
    chk("abort_sol_start", sol_start, 0);
    chk("abort_status_valid", status_valid, 0);
    chk("abort_status", status, 0);
    repeat (2) @(negedge clk);
    user_reset_n = 1'b1;
    push_rows(legal); push_status(ST_OK);
    begin_run();
    drive_rows(legal, 8, 1'b0);
    wait_idle("after_abort");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/eight_queen_run_controller.md
Name: eight_queen_run_controller

Overview:
- Sequences one solve of the stacked eight-queen solver for a host: resets the solver, raises start, waits for done/no_answer under a watchdog.
- Captures the 8-row solution from the solver output bus and checks that it is a legal placement.
- Streams the captured rows to the host over a valid/ready port, then reports a one-cycle status.

Parameters:
- TIMEOUT_CYCLES, 1000000, cycles allowed from start assertion to done/no_answer before the run aborts.
- TIMEOUT_W, 20, watchdog counter width; must hold TIMEOUT_CYCLES.
- RESET_CYCLES, 4, cycles sol_reset is held high before each run (>=1).

Ports:
- clk  in  1  system clock, rising edge
- user_reset_n  in  1  asynchronous active-low reset
- host_req  in  1  single-cycle request to begin a run; ignored unless idle
- host_busy  out  1  high in every state except IDLE
- sol_reset  out  1  active-high reset to solver
- sol_start  out  1  level start to solver
- sol_ready  in  1  solver idle/ready
- sol_done  in  1  solver found solution
- sol_no_answer  in  1  solver exhausted search
- sol_bus  in  8  one-hot column of current row
- rd_valid  out  1  row data valid
- rd_ready  in  1  host accepts row
- rd_data  out  8  captured row, one-hot column
- rd_row  out  3  row index of rd_data
- rd_last  out  1  high with row 7
- status  out  2  0=OK, 1=NO_ANSWER, 2=TIMEOUT, 3=INVALID
- status_valid  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (user_reset_n low, async): state IDLE; all outputs 0, status=0; buffer, counters, masks cleared. Reset mid-run aborts immediately with no status pulse.
- IDLE: host_req=1 -> RST_SOLVER; clear row buffer and capture index.
- RST_SOLVER: sol_reset=1 for exactly RESET_CYCLES cycles -> WAIT_READY.
- WAIT_READY: sol_reset=0; sol_ready=1 -> START; watchdog counts here too and is cleared on entry.
- START: sol_start=1 (held) and watchdog increments every cycle.
  - sol_done=1 -> CAPTURE; capture sol_bus as row 0 in this same cycle.
  - Else sol_no_answer=1 -> status=NO_ANSWER, go to REPORT.
  - Else watchdog reaches TIMEOUT_CYCLES-1 -> status=TIMEOUT, go to REPORT.
  - If sol_done and sol_no_answer are high together, done wins.
- Solver output protocol: row k is on sol_bus in the k-th cycle (k=0..7) counted from the first cycle sol_done is high.
- CAPTURE: sol_start stays 1; rows 1..7 are captured on the next 7 consecutive cycles, independent of sol_done level. Then sol_start=0 -> CHECK.
- Per-row checks during capture:
  - Row not one-hot (zero or multiple bits) sets an invalid flag.
  - Column mask is ORed each row; a bit already set means a column collision and sets the invalid flag.
- CHECK (1 cycle):
  - Combinational check of all 28 row pairs (i<j): abs(col_i - col_j) == j - i means a diagonal conflict and sets the invalid flag.
  - Column index is the log2 of the one-hot byte.
  - Invalid flag set -> status=INVALID, go to REPORT (no stream). Otherwise status=OK -> STREAM.
- STREAM:
  - rd_valid=1, rd_data=buf[idx], rd_row=idx, rd_last=(idx==7).
  - Transfer on rd_valid&rd_ready; idx increments.
  - Outputs are stable while rd_ready=0.
  - Transfer with idx==7 -> REPORT.
  - Back-to-back transfers are allowed, one per cycle.
- REPORT: status_valid=1 for one cycle; status holds its value until the next run starts -> IDLE.
- host_req while busy is ignored (not queued).
- sol_start is never high while sol_reset is high.

Test Plan:
- Legal solution: rows 0x01,0x10,0x80,0x20,0x04,0x40,0x02,0x08 driven after done -> 8 transfers in order, rd_last on row 7, then status=OK with a 1-cycle status_valid; 8 transfers in 8 cycles with rd_ready tied 1.
- Backpressure: toggle rd_ready 1/0 every cycle in STREAM -> each row is transferred exactly once, rd_data/rd_row hold stable while stalled, rows are never skipped or duplicated.
- No answer: sol_no_answer=1 at 30 cycles after start -> no rd_valid, status=NO_ANSWER, sol_start drops the next cycle.
- Timeout: TIMEOUT_CYCLES=50, solver silent -> status_valid occurs 50 cycles after START entry, status=TIMEOUT.
- Invalid placements: a duplicate column (0x01 twice) -> INVALID; rows 0x01,0x02 adjacent (diagonal) -> INVALID; a 0x00 row -> INVALID; none of these is streamed.
- Async reset in CAPTURE at row 4 -> all outputs 0 immediately, no status pulse; a following host_req runs a clean new run with RESET_CYCLES of sol_reset.
